// File: rtl/bloom_stats_pkg.sv
// Shared types and helpers for bloom_match_stats and its match-log FIFO.
package bloom_stats_pkg;
  localparam int LOG_CH_MAX_W  = 16;
  localparam int LOG_IDX_MAX_W = 64;

  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Log entries are stored at maximum width; the top trims to CH_W/CNT_W.
  typedef struct packed {
    logic [LOG_CH_MAX_W-1:0]  ch;
    logic [LOG_IDX_MAX_W-1:0] idx;
  } log_entry_t;

  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] max_val,
                                          input logic        inc);
    return (inc && (val != max_val)) ? val + 64'd1 : val;
  endfunction
endpackage

// File: rtl/bloom_stats_fifo.sv
// Show-ahead FIFO: rd_data_o presents the head whenever empty_o is low.
// A write while full is accepted when a read pops in the same cycle.
module bloom_stats_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_rd, do_wr;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_i && !empty_o;
  assign do_wr     = wr_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/bloom_match_stats.sv
// Per-channel result/match counters with atomic snapshot/clear and registered readout.
// Define BLOOM_MATCH_LOG_EN to add the match-log FIFO and its ports.
module bloom_match_stats
  import bloom_stats_pkg::*;
#(
  parameter int CH_CNT    = 4,
  parameter int CNT_W     = 32,
  parameter int LOG_DEPTH = 16,
  localparam int CH_W     = ch_w(CH_CNT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH_CNT-1:0] match_i,
  input  logic [CH_CNT-1:0] match_val_i,
  input  logic              clear_i,
  input  logic              snapshot_i,
  input  logic              rd_req_i,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic              rd_val_o,
  output logic [CNT_W-1:0]  rd_total_o,
  output logic [CNT_W-1:0]  rd_match_o,
`ifdef BLOOM_MATCH_LOG_EN
  output logic [CH_W-1:0]   log_ch_o,
  output logic [CNT_W-1:0]  log_idx_o,
  output logic              log_val_o,
  input  logic              log_rd_i,
  output logic [CNT_W-1:0]  log_drop_o,
`endif
  output logic              rd_sat_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  total_q [CH_CNT], total_d [CH_CNT];
  logic [CNT_W-1:0]  match_q [CH_CNT], match_d [CH_CNT];
  logic [CH_CNT-1:0] sat_q, sat_d;
  logic [CNT_W-1:0]  sh_total_q [CH_CNT], sh_match_q [CH_CNT];
  logic [CH_CNT-1:0] sh_sat_q;
  logic              rd_val_q, rd_sat_q, rd_sat_d;
  logic [CNT_W-1:0]  rd_total_q, rd_match_q, rd_total_d, rd_match_d;

  // Clear reloads with this cycle's increment so a coincident result is kept.
  always_comb begin
    for (int c = 0; c < CH_CNT; c++) begin
      total_d[c] = CNT_W'(sat_inc(64'(total_q[c]), 64'(CNT_MAX), match_val_i[c]));
      match_d[c] = CNT_W'(sat_inc(64'(match_q[c]), 64'(CNT_MAX),
                                  match_val_i[c] & match_i[c]));
      sat_d[c]   = sat_q[c] | (total_d[c] == CNT_MAX) | (match_d[c] == CNT_MAX);
      if (clear_i) begin
        total_d[c] = CNT_W'(match_val_i[c]);
        match_d[c] = CNT_W'(match_val_i[c] & match_i[c]);
        sat_d[c]   = 1'b0;
      end
    end
  end

  always_comb begin
    rd_total_d = '0;
    rd_match_d = '0;
    rd_sat_d   = 1'b0;
    for (int c = 0; c < CH_CNT; c++) begin
      if (rd_ch_i == CH_W'(c)) begin
        rd_total_d = sh_total_q[c];
        rd_match_d = sh_match_q[c];
        rd_sat_d   = sh_sat_q[c];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int c = 0; c < CH_CNT; c++) begin
        total_q[c]    <= '0;
        match_q[c]    <= '0;
        sh_total_q[c] <= '0;
        sh_match_q[c] <= '0;
      end
      sat_q      <= '0;
      sh_sat_q   <= '0;
      rd_val_q   <= 1'b0;
      rd_total_q <= '0;
      rd_match_q <= '0;
      rd_sat_q   <= 1'b0;
    end else begin
      for (int c = 0; c < CH_CNT; c++) begin
        total_q[c] <= total_d[c];
        match_q[c] <= match_d[c];
        if (snapshot_i) begin
          sh_total_q[c] <= total_q[c];
          sh_match_q[c] <= match_q[c];
        end
      end
      sat_q <= sat_d;
      if (snapshot_i) sh_sat_q <= sat_q;
      rd_val_q <= rd_req_i;
      if (rd_req_i) begin
        rd_total_q <= rd_total_d;
        rd_match_q <= rd_match_d;
        rd_sat_q   <= rd_sat_d;
      end
    end
  end

  assign rd_val_o   = rd_val_q;
  assign rd_total_o = rd_total_q;
  assign rd_match_o = rd_match_q;
  assign rd_sat_o   = rd_sat_q;

`ifdef BLOOM_MATCH_LOG_EN
  logic [CH_CNT-1:0] hit;
  logic              found, fifo_full, fifo_empty, unused_head;
  log_entry_t        wr_entry, head;
  logic [CNT_W:0]    drop_add, drop_sum;
  logic [CNT_W-1:0]  drop_q, drop_d;

  // Lowest matching channel is logged; every other match counts as a drop.
  always_comb begin
    hit      = match_val_i & match_i;
    found    = 1'b0;
    wr_entry = '0;
    drop_add = '0;
    for (int c = 0; c < CH_CNT; c++) begin
      if (hit[c]) begin
        if (!found) begin
          found        = 1'b1;
          wr_entry.ch  = LOG_CH_MAX_W'(c);
          wr_entry.idx = LOG_IDX_MAX_W'(total_d[c]);
        end else begin
          drop_add = drop_add + (CNT_W+1)'(1);
        end
      end
    end
    if (found && fifo_full && !log_rd_i) drop_add = drop_add + (CNT_W+1)'(1);
    drop_sum = clear_i ? drop_add : ({1'b0, drop_q} + drop_add);
    drop_d   = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  bloom_stats_fifo #(
    .WIDTH ($bits(log_entry_t)),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (found),
    .wr_data_i (wr_entry),
    .rd_i      (log_rd_i),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign unused_head = ^head;
  assign log_ch_o    = head.ch[CH_W-1:0];
  assign log_idx_o   = head.idx[CNT_W-1:0];
  assign log_val_o   = !fifo_empty;
  assign log_drop_o  = drop_q;
`else
  localparam int UNUSED_LOG_DEPTH = LOG_DEPTH;
`endif
endmodule

// File: tb/tb_bloom_match_stats.sv
// Scoreboard bench for bloom_match_stats: a default instance (4 ch, 32-bit) and a
// small one (3 ch, 4-bit) for saturation and out-of-range reads.
module tb_bloom_match_stats;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] tot;
    logic [31:0] mat;
    logic        sat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [3:0]  a_mv = '0, a_m = '0;
  logic        a_clr = 0, a_snap = 0, a_req = 0;
  logic [1:0]  a_ch = '0;
  logic        a_rval, a_rsat;
  logic [31:0] a_rtot, a_rmat;

  logic [2:0]  b_mv = '0, b_m = '0;
  logic        b_clr = 0, b_snap = 0, b_req = 0;
  logic [1:0]  b_ch = '0;
  logic        b_rval, b_rsat;
  logic [3:0]  b_rtot, b_rmat;

`ifdef BLOOM_MATCH_LOG_EN
  logic [1:0]  a_lch;
  logic [31:0] a_lidx, a_ldrop;
  logic        a_lval;
  logic        a_lrd = 1'b0;
  logic [1:0]  b_lch;
  logic [3:0]  b_lidx, b_ldrop;
  logic        b_lval;
`endif

  bloom_match_stats dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .match_i     (a_m),
    .match_val_i (a_mv),
    .clear_i     (a_clr),
    .snapshot_i  (a_snap),
    .rd_req_i    (a_req),
    .rd_ch_i     (a_ch),
    .rd_val_o    (a_rval),
    .rd_total_o  (a_rtot),
    .rd_match_o  (a_rmat),
`ifdef BLOOM_MATCH_LOG_EN
    .log_ch_o    (a_lch),
    .log_idx_o   (a_lidx),
    .log_val_o   (a_lval),
    .log_rd_i    (a_lrd),
    .log_drop_o  (a_ldrop),
`endif
    .rd_sat_o    (a_rsat)
  );

  bloom_match_stats #(.CH_CNT(3), .CNT_W(4)) dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .match_i     (b_m),
    .match_val_i (b_mv),
    .clear_i     (b_clr),
    .snapshot_i  (b_snap),
    .rd_req_i    (b_req),
    .rd_ch_i     (b_ch),
    .rd_val_o    (b_rval),
    .rd_total_o  (b_rtot),
    .rd_match_o  (b_rmat),
`ifdef BLOOM_MATCH_LOG_EN
    .log_ch_o    (b_lch),
    .log_idx_o   (b_lidx),
    .log_val_o   (b_lval),
    .log_rd_i    (1'b0),
    .log_drop_o  (b_ldrop),
`endif
    .rd_sat_o    (b_rsat)
  );

  // Monitors: pop the scoreboard whenever a DUT presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (a_rval) begin
      n_run++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_rd_val at cycle %0d", cyc);
      end else begin
        e = qa.pop_front();
        if (cyc != e.due || a_rtot != e.tot || a_rmat != e.mat || a_rsat != e.sat) begin
          n_fail++;
          $display("FAIL a_read got cyc=%0d tot=%0d mat=%0d sat=%0d, expected cyc=%0d tot=%0d mat=%0d sat=%0d",
                   cyc, a_rtot, a_rmat, a_rsat, e.due, e.tot, e.mat, e.sat);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rval) begin
      n_run++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_rd_val at cycle %0d", cyc);
      end else begin
        e = qb.pop_front();
        if (cyc != e.due || b_rtot != e.tot[3:0] || b_rmat != e.mat[3:0] || b_rsat != e.sat) begin
          n_fail++;
          $display("FAIL b_read got cyc=%0d tot=%0d mat=%0d sat=%0d, expected cyc=%0d tot=%0d mat=%0d sat=%0d",
                   cyc, b_rtot, b_rmat, b_rsat, e.due, e.tot, e.mat, e.sat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // All drive tasks start and end on a negative clock edge.
  task automatic a_cyc(input logic [3:0] mv, input logic [3:0] m, input logic clr,
                       input logic snap, input logic req, input logic [1:0] ch,
                       input logic [31:0] et, input logic [31:0] em, input logic es);
    a_mv = mv; a_m = m; a_clr = clr; a_snap = snap; a_req = req; a_ch = ch;
    if (req) qa.push_back('{due: cyc + 1, tot: et, mat: em, sat: es});
    @(negedge clk);
    a_mv = '0; a_m = '0; a_clr = 0; a_snap = 0; a_req = 0;
  endtask

  task automatic a_evt(input logic [3:0] mv, input logic [3:0] m, input logic clr, input logic snap);
    a_cyc(mv, m, clr, snap, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic a_read(input logic [1:0] ch, input logic [31:0] et, input logic [31:0] em, input logic es);
    a_cyc(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, ch, et, em, es);
  endtask

  task automatic b_cyc(input logic [2:0] mv, input logic [2:0] m, input logic clr,
                       input logic snap, input logic req, input logic [1:0] ch,
                       input logic [31:0] et, input logic [31:0] em, input logic es);
    b_mv = mv; b_m = m; b_clr = clr; b_snap = snap; b_req = req; b_ch = ch;
    if (req) qb.push_back('{due: cyc + 1, tot: et, mat: em, sat: es});
    @(negedge clk);
    b_mv = '0; b_m = '0; b_clr = 0; b_snap = 0; b_req = 0;
  endtask

  task automatic b_evt(input logic [2:0] mv, input logic [2:0] m, input logic clr, input logic snap);
    b_cyc(mv, m, clr, snap, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic b_read(input logic [1:0] ch, input logic [31:0] et, input logic [31:0] em, input logic es);
    b_cyc(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, ch, et, em, es);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_rd_val_in_reset", a_rval, 0);
    chk("a_rd_total_in_reset", a_rtot, 0);
    chk("b_rd_val_in_reset", b_rval, 0);
    rst = 1'b1;

    // Reset state readback
    a_evt(4'd0, 4'd0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) a_read(2'(c), 32'd0, 32'd0, 1'b0);
    b_evt(3'd0, 3'd0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) b_read(2'(c), 32'd0, 32'd0, 1'b0);
    @(negedge clk);

`ifdef BLOOM_MATCH_LOG_EN
    a_evt(4'b1001, 4'b1001, 1'b0, 1'b0);
    chk("log_val_first", a_lval, 1);
    chk("log_ch_first", a_lch, 0);
    chk("log_idx_first", a_lidx, 1);
    chk("log_drop_loser", a_ldrop, 1);
    a_lrd = 1'b1;
    @(negedge clk);
    a_lrd = 1'b0;
    chk("log_val_after_pop", a_lval, 0);
    for (int i = 0; i < 16; i++) a_evt(4'b0010, 4'b0010, 1'b0, 1'b0);
    chk("log_drop_full_no_drop", a_ldrop, 1);
    a_evt(4'b0010, 4'b0010, 1'b0, 1'b0);
    chk("log_drop_full_write", a_ldrop, 2);
    a_lrd = 1'b1;
    a_evt(4'b0010, 4'b0010, 1'b0, 1'b0);
    a_lrd = 1'b0;
    chk("log_drop_pop_push", a_ldrop, 2);
    chk("log_head_ch_after_pop", a_lch, 1);
    chk("log_head_idx_after_pop", a_lidx, 2);
    a_evt(4'd0, 4'd0, 1'b1, 1'b0);
    chk("log_drop_cleared", a_ldrop, 0);
    chk("log_not_flushed", a_lval, 1);
`endif

    // Counting: 10 results on ch1, matches on results 2, 5, 9
    for (int i = 1; i <= 10; i++)
      a_evt(4'b0010, (i == 2 || i == 5 || i == 9) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
    a_evt(4'd0, 4'd0, 1'b0, 1'b1);
    a_read(2'd1, 32'd10, 32'd3, 1'b0);
    a_read(2'd0, 32'd0, 32'd0, 1'b0);
    a_read(2'd2, 32'd0, 32'd0, 1'b0);
    a_read(2'd3, 32'd0, 32'd0, 1'b0);

    // Read-and-clear race on ch0 (total 7, match 2), with a same-cycle read of old ch1 shadow
    a_evt(4'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) a_evt(4'b0001, (i <= 2) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
    a_cyc(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd1, 32'd10, 32'd3, 1'b0);
    a_read(2'd0, 32'd7, 32'd2, 1'b0);
    a_evt(4'd0, 4'd0, 1'b0, 1'b1);
    a_read(2'd0, 32'd1, 32'd1, 1'b0);
    a_read(2'd1, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("a_hold_rd_val_low", a_rval, 0);
    chk("a_hold_total", a_rtot, 0);
    a_read(2'd0, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    chk("a_hold_match", a_rmat, 1);

    // Saturation on the 4-bit instance: 20 results, 10 matches on ch2
    for (int i = 0; i < 20; i++) b_evt(3'b100, (i % 2 == 0) ? 3'b100 : 3'b000, 1'b0, 1'b0);
    b_evt(3'd0, 3'd0, 1'b0, 1'b1);
    b_read(2'd2, 32'd15, 32'd10, 1'b1);
    b_read(2'd3, 32'd0, 32'd0, 1'b0);
    b_read(2'd1, 32'd0, 32'd0, 1'b0);
    b_evt(3'd0, 3'd0, 1'b1, 1'b0);
    b_evt(3'd0, 3'd0, 1'b0, 1'b1);
    b_read(2'd2, 32'd0, 32'd0, 1'b0);
    b_read(2'd3, 32'd0, 32'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("a_scoreboard_drained", 64'(qa.size()), 0);
    chk("b_scoreboard_drained", 64'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/bloom_match_stats.md
Name: bloom_match_stats

Overview:
- Multi-channel statistics collector for Bloom-filter results; sits after CH_CNT parallel top_bloom instances.
- Counts results and matches per channel in hardware, replacing bench-side counting.
- Supports atomic snapshot/clear and a registered readout port for host or bench polling.

Parameters:
- CH_CNT, 4, number of Bloom-filter result channels (>=1)
- CNT_W, 32, width of each total/match counter (>=2)
- LOG_DEPTH, 16, match-log FIFO depth, power of 2; used only with the optional feature

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-low
- match_i  in  CH_CNT  per-channel match flag, qualified by match_val_i
- match_val_i  in  CH_CNT  per-channel result-valid strobe
- clear_i  in  1  zero all live counters and saturation flags
- snapshot_i  in  1  copy live counters into shadow registers
- rd_req_i  in  1  read request for shadow channel rd_ch_i
- rd_ch_i  in  CH_W=max(1,$clog2(CH_CNT))  channel to read
- rd_val_o  out  1  read data valid pulse
- rd_total_o  out  CNT_W  shadow total-result count
- rd_match_o  out  CNT_W  shadow match count
- rd_sat_o  out  1  shadow saturation flag (either counter saturated)

Behaviour:
- Reset (rst_i==0 at posedge): all live and shadow counters, flags and outputs are 0. Log FIFO is empty and log_drop_o is 0.
- Per channel c, in a cycle with match_val_i[c]:
  - total[c] += 1.
  - match[c] += 1 if match_i[c].
  - match_i is ignored while match_val_i is low.
- Saturation: a counter at 2^CNT_W-1 holds that value and sets sticky sat[c]. Only clear_i or reset releases it.
- clear_i: live counters reload with that cycle's increment (0 or 1), so the same-cycle event is not lost. sat is cleared unless the reload itself saturates (CNT_W>=2, so it never does).
- snapshot_i: shadow captures the live register values before the current cycle's increment.
- snapshot_i and clear_i in the same cycle form an atomic read-and-clear. The shadow gets the pre-clear values and the live counters reload as above.
- Read: rd_req_i at cycle N gives rd_val_o=1 at N+1, with rd_total_o, rd_match_o and rd_sat_o taken from shadow[rd_ch_i].
  - Back-to-back requests are allowed, one per cycle.
  - rd_ch_i>=CH_CNT returns all-zero data with rd_val_o still 1.
  - Outputs hold their last value when rd_val_o=0.
- A read in the same cycle as a snapshot returns the old shadow value. The new value is visible from the next request.
- No state machine beyond the counters. Latency from input event to counter is 1 cycle.

Optional Feature:
- Macro BLOOM_MATCH_LOG_EN.
- With the macro defined, these ports are added:
  - log_ch_o (CH_W)
  - log_idx_o (CNT_W)
  - log_val_o
  - log_rd_i
  - log_drop_o (CNT_W)
- Every cycle with any match_val_i&match_i, one entry {channel, index} is written. The index is the 1-based post-increment total[c] of that event.
- When several channels match in the same cycle, the lowest channel wins. Each losing match adds 1 to log_drop_o.
- FIFO is show-ahead: log_val_o=1 while non-empty, and log_rd_i pops the head.
- Write when full: the entry is dropped and log_drop_o increments, unless log_rd_i pops in the same cycle. In that case the write is accepted.
- log_drop_o saturates. clear_i zeroes log_drop_o but does not flush the FIFO.
- Without the macro, none of these ports or the FIFO exist, and the counter behaviour is identical.

Decomposition:
- Package bloom_stats_pkg holds:
  - ch_w function (max(1,$clog2(n)))
  - typedef log_entry_t {ch, idx}
  - saturating-increment function
- One sub-module, bloom_stats_fifo: parametrised show-ahead FIFO with full/empty and simultaneous read/write handling. Instantiated only under BLOOM_MATCH_LOG_EN.

Test Plan:
- Reset state: hold rst_i=0 for 2 cycles, then snapshot and read ch0..3 -> all rd_total/rd_match=0, rd_sat=0, rd_val_o one cycle after each rd_req_i.
- Counting: send 10 results on ch1 with match on results 2, 5 and 9, then snapshot and read ch1 -> total=10, match=3; ch0/2/3 read 0.
- Read-and-clear race: with ch0 total=7, assert snapshot_i+clear_i together with match_val_i[0]=1, match_i[0]=1 -> shadow total=7; next snapshot shows live total=1, match=1.
- Saturation: CNT_W=4, 20 results on ch2 -> total=15, rd_sat=1; clear_i -> total=0, sat=0.
- Out-of-range read: CH_CNT=3, rd_ch_i=3 -> rd_val_o=1 with all-zero data.
- Log (macro on): ch0 and ch3 match simultaneously as their first results -> log entry {0,1}, log_drop_o=1. Fill LOG_DEPTH=16 with one more write -> drop increments. Full with pop and push in the same cycle -> entry accepted, count unchanged.
